// File: rtl/power_arb_pkg.sv
// Shared types and constants for the hood power request arbiter.
package power_arb_pkg;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_e;

    localparam logic [1:0] SRC_NONE    = 2'b00;
    localparam logic [1:0] SRC_KEY     = 2'b01;
    localparam logic [1:0] SRC_GESTURE = 2'b10;
    localparam logic [1:0] SRC_TIMEOUT = 2'b11;

    // Key requests outrank gesture requests arriving in the same cycle.
    function automatic logic [1:0] pick_src(input logic key_req);
        return key_req ? SRC_KEY : SRC_GESTURE;
    endfunction

endpackage

// File: rtl/power_request_arbiter_lockout_timer.sv
// Load/decrement window timer (UP_COUNT=0) or clear/increment idle timer
// (UP_COUNT=1). In down mode, active is high for exactly LIMIT cycles after
// a load. In up mode, active flags that the count sits at LIMIT-1, so the
// next enabled cycle is the LIMIT-th one.
module lockout_timer #(
    parameter int CNT_W    = 32,
    parameter int LIMIT    = 1,
    parameter bit UP_COUNT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    input  logic clear,
    output logic active
);

    logic [CNT_W-1:0] cnt;

    // Counter and registered active flag; behaviour chosen by UP_COUNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            active <= (UP_COUNT && (LIMIT == 1));
        end else if (UP_COUNT) begin
            if (clear || load) begin
                cnt    <= '0;
                active <= (LIMIT == 1);
            end else if (enable) begin
                cnt    <= cnt + CNT_W'(1);
                active <= ((cnt + CNT_W'(1)) == CNT_W'(LIMIT - 1));
            end
        end else begin
            if (load) begin
                cnt    <= CNT_W'(LIMIT);
                active <= 1'b1;
            end else if (cnt != '0) begin
                cnt    <= cnt - CNT_W'(1);
                active <= (cnt > CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/power_request_arbiter.sv
// Hood power request arbiter: merges key and gesture power requests into a
// single registered power state with source priority, a post-transition
// lockout window and a single deferred request.
// Optional build macro AUTO_OFF_EN adds an idle timer that forces OFF after
// IDLE_CYCLES quiet cycles while ON.
module power_request_arbiter
    import power_arb_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 100_000_000,
    parameter int IDLE_CYCLES    = 500_000_000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       short_press,
    input  logic       long_press,
    input  logic       gesture_on_req,
    input  logic       gesture_off_req,
    output logic       power_state,
    output logic [1:0] last_src,
    output logic       lockout,
    output logic       pending
);

    pwr_state_e state_q, state_d;
    logic [1:0] last_src_q, last_src_d;
    logic [1:0] pend_src_q, pend_src_d;
    logic       pend_q, pend_d;
    logic       do_load;
    logic       lock_active;
    logic       req;
    logic       req_key;
    logic       cancel;
    logic       timeout;

    // Decode the raw pulses into the request that matters in the current
    // state, plus the opposite-direction request that cancels a deferral.
    always_comb begin
        req     = 1'b0;
        req_key = 1'b0;
        cancel  = 1'b0;
        if (state_q == PWR_ON) begin
            req     = long_press | gesture_off_req;
            req_key = long_press;
            cancel  = short_press | gesture_on_req;
        end else begin
            req     = short_press | long_press | gesture_on_req;
            req_key = short_press | long_press;
            cancel  = gesture_off_req;
        end
    end

    // Next-state logic: defer during lockout, otherwise fresh request,
    // then held request, then idle timeout, in that order.
    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        pend_d     = pend_q;
        pend_src_d = pend_src_q;
        do_load    = 1'b0;
        if (lock_active) begin
            if (req) begin
                if (!pend_q) begin
                    pend_d     = 1'b1;
                    pend_src_d = pick_src(req_key);
                end
            end else if (cancel) begin
                pend_d = 1'b0;
            end
        end else if (req) begin
            state_d    = (state_q == PWR_ON) ? PWR_OFF : PWR_ON;
            last_src_d = pick_src(req_key);
            pend_d     = 1'b0;
            do_load    = 1'b1;
        end else if (pend_q) begin
            state_d    = (state_q == PWR_ON) ? PWR_OFF : PWR_ON;
            last_src_d = pend_src_q;
            pend_d     = 1'b0;
            do_load    = 1'b1;
        end else if (timeout) begin
            state_d    = PWR_OFF;
            last_src_d = SRC_TIMEOUT;
            do_load    = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PWR_OFF;
            last_src_q <= SRC_NONE;
            pend_q     <= 1'b0;
            pend_src_q <= SRC_NONE;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
        end
    end

    lockout_timer #(
        .CNT_W   (CNT_W),
        .LIMIT   (LOCKOUT_CYCLES),
        .UP_COUNT(1'b0)
    ) u_lockout (
        .clk   (clk),
        .reset (reset),
        .load  (do_load),
        .enable(1'b0),
        .clear (1'b0),
        .active(lock_active)
    );

`ifdef AUTO_OFF_EN
    logic any_pulse;
    logic idle_clear;
    logic idle_near;

    // The idle count only advances in quiet ON cycles outside lockout; a
    // held request about to be applied is a transition, so it clears too.
    always_comb begin
        any_pulse  = short_press | long_press | gesture_on_req | gesture_off_req;
        idle_clear = (state_q != PWR_ON) | lock_active | any_pulse | pend_q;
        timeout    = idle_near & ~idle_clear;
    end

    lockout_timer #(
        .CNT_W   (CNT_W),
        .LIMIT   (IDLE_CYCLES),
        .UP_COUNT(1'b1)
    ) u_idle (
        .clk   (clk),
        .reset (reset),
        .load  (1'b0),
        .enable(1'b1),
        .clear (idle_clear),
        .active(idle_near)
    );
`else
    assign timeout = 1'b0;
`endif

    assign power_state = (state_q == PWR_ON);
    assign last_src    = last_src_q;
    assign lockout     = lock_active;
    assign pending     = pend_q;

endmodule

// File: tb/tb_power_request_arbiter.sv
// Self-checking bench for power_request_arbiter (LOCKOUT_CYCLES=4,
// IDLE_CYCLES=10). Define AUTO_OFF_EN to exercise the idle timeout.
module tb_power_request_arbiter;

    localparam int LOCK = 4;
    localparam int IDLE = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       short_press = 1'b0;
    logic       long_press = 1'b0;
    logic       gesture_on_req = 1'b0;
    logic       gesture_off_req = 1'b0;
    logic       power_state;
    logic [1:0] last_src;
    logic       lockout;
    logic       pending;

    int checks = 0;
    int errors = 0;

    power_request_arbiter #(
        .LOCKOUT_CYCLES(LOCK),
        .IDLE_CYCLES   (IDLE),
        .CNT_W         (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .short_press    (short_press),
        .long_press     (long_press),
        .gesture_on_req (gesture_on_req),
        .gesture_off_req(gesture_off_req),
        .power_state    (power_state),
        .last_src       (last_src),
        .lockout        (lockout),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Reference model: remaining lockout cycles, a one-slot deferred
    // request, and a quiet-cycle tally, all as plain integers.
    int m_on, m_src, m_lock_left, m_pend, m_pend_src, m_quiet;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_on = 0; m_src = 0; m_lock_left = 0;
            m_pend = 0; m_pend_src = 0; m_quiet = 0;
        end else begin
            int  want, want_key, opposite, any_in, locked, go, go_src;
            any_in   = short_press | long_press | gesture_on_req | gesture_off_req;
            want     = m_on ? (long_press | gesture_off_req)
                            : (short_press | long_press | gesture_on_req);
            want_key = m_on ? long_press : (short_press | long_press);
            opposite = m_on ? (short_press | gesture_on_req) : gesture_off_req;
            locked   = (m_lock_left > 0);
            go = 0; go_src = 0;
            if (locked) begin
                m_lock_left = m_lock_left - 1;
                if (want != 0) begin
                    if (m_pend == 0) begin
                        m_pend = 1;
                        m_pend_src = (want_key != 0) ? 1 : 2;
                    end
                end else if (opposite != 0) begin
                    m_pend = 0;
                end
            end else if (want != 0) begin
                go = 1; go_src = (want_key != 0) ? 1 : 2;
            end else if (m_pend != 0) begin
                go = 1; go_src = m_pend_src;
            end
`ifdef AUTO_OFF_EN
            if (!go && m_on == 1 && !locked && any_in == 0 && m_pend == 0) begin
                m_quiet = m_quiet + 1;
                if (m_quiet == IDLE) begin
                    go = 1; go_src = 3;
                end
            end else begin
                m_quiet = 0;
            end
`else
            m_quiet = any_in;
`endif
            if (go) begin
                m_on = (m_on != 0) ? 0 : 1;
                m_src = go_src;
                m_pend = 0;
                m_lock_left = LOCK;
                m_quiet = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (int'(power_state) != m_on) begin
                errors++;
                $display("FAIL model_power_state t=%0t actual=%0d expected=%0d", $time, power_state, m_on);
            end
            checks++;
            if (int'(last_src) != m_src) begin
                errors++;
                $display("FAIL model_last_src t=%0t actual=%0d expected=%0d", $time, last_src, m_src);
            end
            checks++;
            if (int'(lockout) != ((m_lock_left > 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL model_lockout t=%0t actual=%0d expected=%0d", $time, lockout, (m_lock_left > 0));
            end
            checks++;
            if (int'(pending) != m_pend) begin
                errors++;
                $display("FAIL model_pending t=%0t actual=%0d expected=%0d", $time, pending, m_pend);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one-cycle pulses sampled on the next rising edge.
    task automatic pulse(input logic s, input logic l, input logic gon, input logic goff);
        short_press = s; long_press = l; gesture_on_req = gon; gesture_off_req = goff;
        tick();
        short_press = 1'b0; long_press = 1'b0; gesture_on_req = 1'b0; gesture_off_req = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        chk("reset_power", power_state, 0);
        chk("reset_src", last_src, 0);
        chk("reset_lockout", lockout, 0);
        chk("reset_pending", pending, 0);

        // Power on and lockout length.
        tick(2);
        pulse(1, 0, 0, 0);
        chk("on_power", power_state, 1);
        chk("on_src", last_src, 1);
        chk("on_lock_c1", lockout, 1);
        for (int i = 0; i < LOCK - 1; i++) begin
            tick();
            chk("on_lock_hold", lockout, 1);
        end
        tick();
        chk("on_lock_release", lockout, 0);

        // Priority: key beats gesture in both directions.
        pulse(0, 1, 0, 1);
        chk("prio_off_power", power_state, 0);
        chk("prio_off_src", last_src, 1);
        tick(LOCK);
        pulse(1, 0, 1, 0);
        chk("prio_on_power", power_state, 1);
        chk("prio_on_src", last_src, 1);

        // Deferred gesture OFF during lockout.
        pulse(0, 0, 0, 1);
        chk("defer_pending", pending, 1);
        chk("defer_power_held", power_state, 1);
        tick(3);
        chk("defer_free_lock", lockout, 0);
        chk("defer_free_power", power_state, 1);
        tick();
        chk("defer_apply_power", power_state, 0);
        chk("defer_apply_src", last_src, 2);
        chk("defer_apply_pending", pending, 0);
        chk("defer_apply_lock", lockout, 1);

        // Cancel: pending OFF undone by an ON-direction request.
        tick(LOCK);
        pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        chk("cancel_set", pending, 1);
        pulse(0, 0, 1, 0);
        chk("cancel_clear", pending, 0);
        tick(LOCK + 2);
        chk("cancel_power", power_state, 1);

        // Same-direction repeat keeps the first (gesture) source.
        pulse(0, 1, 0, 0);
        chk("repeat_off", power_state, 0);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        tick(3);
        chk("repeat_power", power_state, 1);
        chk("repeat_src", last_src, 2);

        // Fresh request at release beats the held one.
        pulse(0, 0, 0, 1);
        tick(3);
        pulse(0, 1, 0, 0);
        chk("fresh_power", power_state, 0);
        chk("fresh_src", last_src, 1);
        chk("fresh_pending", pending, 0);

        // Asynchronous reset mid-lockout with pending set.
        pulse(0, 0, 1, 0);
        chk("prereset_pending", pending, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_power", power_state, 0);
        chk("async_src", last_src, 0);
        chk("async_lockout", lockout, 0);
        chk("async_pending", pending, 0);
        tick(2);
        reset = 1'b0;
        pulse(1, 0, 0, 0);
        chk("post_reset_power", power_state, 1);
        chk("post_reset_src", last_src, 1);

`ifdef AUTO_OFF_EN
        // Auto-off after IDLE quiet cycles past the lockout.
        tick(LOCK);
        tick(IDLE - 1);
        chk("idle_still_on", power_state, 1);
        tick();
        chk("idle_off_power", power_state, 0);
        chk("idle_off_src", last_src, 3);
        chk("idle_off_lock", lockout, 1);
        // A pulse at quiet cycle 9 restarts the count.
        tick(LOCK);
        pulse(1, 0, 0, 0);
        tick(LOCK);
        tick(IDLE - 2);
        pulse(0, 0, 1, 0);
        tick(IDLE - 1);
        chk("idle_restart_on", power_state, 1);
        tick();
        chk("idle_restart_off", power_state, 0);
        chk("idle_restart_src", last_src, 3);
`else
        // Without auto-off, ON holds indefinitely.
        tick(3 * IDLE);
        chk("hold_power", power_state, 1);
        chk("hold_src", last_src, 1);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
